// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// FSM states are plain logic constants so older tools can consume them unchanged.
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH = 256;
  localparam int unsigned DMEM_DW    = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ACCESS  = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;
  localparam state_t ST_RESP    = 2'd3;

  typedef logic port_idx_t;

  localparam port_idx_t PORT0 = 1'b0;
  localparam port_idx_t PORT1 = 1'b1;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-input arbiter producing a one-hot grant.
// DMEM_ARB_RR_EN selects round-robin on ties; otherwise port 0 has fixed priority.
module dmem_rr_pick
  import dmem_pkg::*;
(
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
`ifdef DMEM_ARB_RR_EN
  ,
  input  port_idx_t  i_last
`endif
);

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    o_gnt = i_req;
    // On a tie the port that did not win last time goes first.
    if (i_req == 2'b11) begin
      o_gnt = (i_last == PORT1) ? 2'b01 : 2'b10;
    end
  end
`else
  always_comb begin
    o_gnt = i_req[0] ? 2'b01 : {i_req[1], 1'b0};
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port access controller for the data memory: arbitrate, latch, one strobed access, respond.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; default build is fixed priority to port 0.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  parameter int unsigned AW    = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req0,
  input  logic               i_we0,
  input  logic [AW-1:0]      i_addr0,
  input  logic [DMEM_DW-1:0] i_wdata0,
  input  logic               i_req1,
  input  logic               i_we1,
  input  logic [AW-1:0]      i_addr1,
  input  logic [DMEM_DW-1:0] i_wdata1,
  output logic               o_gnt0,
  output logic               o_gnt1,
  output logic               o_rsp_valid0,
  output logic               o_rsp_valid1,
  output logic [DMEM_DW-1:0] o_rsp_data,
  output logic               o_rsp_err,
  output logic [31:0]        o_mem_addr,
  output logic [DMEM_DW-1:0] o_mem_wdata,
  output logic               o_mem_read,
  output logic               o_mem_write,
  input  logic [DMEM_DW-1:0] i_mem_rdata,
  output logic               o_busy
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  state_t             r_state;
  state_t             w_state_d;
  port_idx_t          r_owner;
  logic               r_we;
  logic               r_err;
  logic [31:0]        r_mem_addr;
  logic [DMEM_DW-1:0] r_mem_wdata;
  logic [DMEM_DW-1:0] r_rsp_data;
  logic               r_rsp_err;

  logic [1:0]         w_req;
  logic [1:0]         w_pick;
  logic [1:0]         w_gnt;
  logic               w_fire;
  port_idx_t          w_win;
  logic               w_sel_we;
  logic [AW-1:0]      w_sel_addr;
  logic [DMEM_DW-1:0] w_sel_wdata;
  logic               w_addr_err;

  assign w_req = {i_req1, i_req0};

`ifdef DMEM_ARB_RR_EN
  port_idx_t r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= PORT1;
    end else if (w_fire) begin
      r_last <= w_win;
    end
  end

  dmem_rr_pick u_pick (
    .i_req  (w_req),
    .o_gnt  (w_pick),
    .i_last (r_last)
  );
`else
  dmem_rr_pick u_pick (
    .i_req (w_req),
    .o_gnt (w_pick)
  );
`endif

  assign w_gnt       = (r_state == ST_IDLE) ? w_pick : 2'b00;
  assign w_fire      = |w_gnt;
  assign w_win       = w_gnt[1] ? PORT1 : PORT0;
  assign w_sel_we    = (w_win == PORT1) ? i_we1 : i_we0;
  assign w_sel_addr  = (w_win == PORT1) ? i_addr1 : i_addr0;
  assign w_sel_wdata = (w_win == PORT1) ? i_wdata1 : i_wdata0;
  assign w_addr_err  = {1'b0, w_sel_addr} >= LP_DEPTH;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE:    if (w_fire) w_state_d = ST_ACCESS;
      ST_ACCESS:  w_state_d = ST_CAPTURE;
      ST_CAPTURE: w_state_d = ST_RESP;
      ST_RESP:    w_state_d = ST_IDLE;
      default:    w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= PORT1;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_fire) begin
        r_owner <= w_win;
        r_we    <= w_sel_we;
        r_err   <= w_addr_err;
        // Rejected requests leave the memory bus untouched so it never moves unstrobed.
        if (!w_addr_err) begin
          r_mem_addr  <= 32'(w_sel_addr);
          r_mem_wdata <= w_sel_wdata;
        end
      end
      if (r_state == ST_CAPTURE) begin
        r_rsp_data <= (!r_err && !r_we) ? i_mem_rdata : '0;
        r_rsp_err  <= r_err;
      end
    end
  end

  assign o_gnt0       = w_gnt[0];
  assign o_gnt1       = w_gnt[1];
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_read   = (r_state == ST_ACCESS) && !r_err && !r_we;
  assign o_mem_write  = (r_state == ST_ACCESS) && !r_err && r_we;
  assign o_rsp_valid0 = (r_state == ST_RESP) && (r_owner == PORT0);
  assign o_rsp_valid1 = (r_state == ST_RESP) && (r_owner == PORT1);
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_err    = r_rsp_err;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, corner sequences, random vs. model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, mem_read, mem_write, busy;
  logic [31:0] rsp_data, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0       (req0),
    .i_we0        (we0),
    .i_addr0      (addr0),
    .i_wdata0     (wdata0),
    .i_req1       (req1),
    .i_we1        (we1),
    .i_addr1      (addr1),
    .i_wdata1     (wdata1),
    .o_gnt0       (gnt0),
    .o_gnt1       (gnt1),
    .o_rsp_valid0 (rsp_valid0),
    .o_rsp_valid1 (rsp_valid1),
    .o_rsp_data   (rsp_data),
    .o_rsp_err    (rsp_err),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_read   (mem_read),
    .o_mem_write  (mem_write),
    .i_mem_rdata  (mem_rdata),
    .o_busy       (busy)
  );

  // Attached memory: synchronous read, word i initialised to i.
  logic [31:0] sim_mem [256];
  logic        mem_inited = 1'b0;

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 256; i++) sim_mem[i] <= 32'(i);
      mem_inited <= 1'b1;
    end else begin
      if (mem_write) sim_mem[mem_addr[7:0]] <= mem_wdata;
      if (mem_read) mem_rdata <= sim_mem[mem_addr[7:0]];
    end
  end

  // Bus protocol monitor.
  logic [31:0] prev_addr = '0;
  int          mon_bad = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_addr <= mem_addr;
    end else begin
      if (mem_read && mem_write) begin
        mon_bad <= mon_bad + 1;
        $display("FAIL strobe_excl: read=%0b write=%0b, need not both", mem_read, mem_write);
      end
      if (gnt0 && gnt1) begin
        mon_bad <= mon_bad + 1;
        $display("FAIL gnt_onehot: gnt0=%0b gnt1=%0b, need not both", gnt0, gnt1);
      end
      if (mem_addr != prev_addr && !(mem_read || mem_write)) begin
        mon_bad <= mon_bad + 1;
        $display("FAIL addr_unstrobed: addr 0x%0h -> 0x%0h with no strobe", prev_addr, mem_addr);
      end
      prev_addr <= mem_addr;
    end
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ref_mem [256];
  logic        model_last = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pick_port(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
      return model_last ? 0 : 1;
`else
      return 0;
`endif
    end
    return r0 ? 0 : 1;
  endfunction

  function automatic logic [127:0] all_outs();
    return {mem_addr, mem_wdata, rsp_data,
            gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, mem_read, mem_write, busy};
  endfunction

  typedef struct {
    logic r0, r1, we0, we1;
    logic [31:0] a0, a1, d0, d1;
    int          ep;
    logic [31:0] edata;
    logic        eerr;
  } vec_t;

  function automatic vec_t mk(input logic r0, r1, we0, we1, input logic [31:0] a0, a1, d0, d1,
                              input int ep, input logic [31:0] edata, input logic eerr);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.we0 = we0; v.we1 = we1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.ep = ep; v.edata = edata; v.eerr = eerr;
    return v;
  endfunction

  // Entered just after a rising edge with the DUT idle; leaves it the same way.
  task automatic run_txn(input string tag, input vec_t v);
    logic        got, ewe, erd, ewr;
    logic [31:0] ea, ed;
    int          k;
    req0 = v.r0; we0 = v.we0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.we1; addr1 = v.a1; wdata1 = v.d1;
    got = 1'b0;
    k = 0;
    while (!got && k < 8) begin
      @(negedge clk);
      got = gnt0 | gnt1;
      k++;
    end
    check({tag, " grant"}, {gnt1, gnt0}, (v.ep == 0) ? 2'b01 : 2'b10);
    ewe = (v.ep == 0) ? v.we0 : v.we1;
    ea  = (v.ep == 0) ? v.a0 : v.a1;
    ed  = (v.ep == 0) ? v.d0 : v.d1;
    erd = !v.eerr && !ewe;
    ewr = !v.eerr && ewe;
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check({tag, " access busy/rd/wr"}, {busy, mem_read, mem_write}, {1'b1, erd, ewr});
    if (erd || ewr) check({tag, " mem_addr"}, mem_addr, ea);
    if (ewr) check({tag, " mem_wdata"}, mem_wdata, ed);
    @(negedge clk);
    check({tag, " capture quiet"}, {mem_read, mem_write, rsp_valid0, rsp_valid1}, 4'b0);
    @(negedge clk);
    check({tag, " rsp_valid"}, {rsp_valid1, rsp_valid0}, (v.ep == 0) ? 2'b01 : 2'b10);
    check({tag, " rsp_data"}, rsp_data, v.edata);
    check({tag, " rsp_err"}, rsp_err, v.eerr);
    @(negedge clk);
    check({tag, " back to idle"}, {busy, rsp_valid0, rsp_valid1}, 3'b0);
    @(posedge clk); #1;
    if (ewr) ref_mem[ea[7:0]] = ed;
    model_last = (v.ep == 1);
  endtask

  vec_t tbl [10];

  initial begin
    int          gp [4];
    int          gc [4];
    int          ng, n1, v0n, ep;
    logic [31:0] d;
    logic        any;
    vec_t        rv;

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);

    tbl[0] = mk(1, 0, 0, 0, 7, 0, 0, 0, 0, 7, 0);
    tbl[1] = mk(0, 1, 0, 1, 0, 10, 0, 32'hDEADBEEF, 1, 0, 0);
    tbl[2] = mk(0, 1, 0, 0, 0, 10, 0, 0, 1, 32'hDEADBEEF, 0);
    tbl[3] = mk(1, 0, 0, 0, 256, 0, 0, 0, 0, 0, 1);
    tbl[4] = mk(1, 0, 1, 0, 255, 0, 32'h12345678, 0, 0, 0, 0);
    tbl[5] = mk(0, 1, 0, 0, 0, 255, 0, 0, 1, 32'h12345678, 0);
    tbl[6] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[7] = mk(0, 1, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 1);
    tbl[8] = mk(0, 1, 0, 1, 0, 300, 0, 32'h0000AAAA, 1, 0, 1);
    tbl[9] = mk(1, 0, 0, 0, 44, 0, 0, 0, 0, 44, 0);

    #3;
    check("reset outputs", all_outs(), 128'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle after reset busy", busy, 1'b0);

    // Both ports held high: one grant every 4 cycles, order set by arbitration policy.
    req0 = 1'b1; we0 = 1'b0; addr0 = 3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5;
    ng = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        if (ng < 4) begin
          gp[ng] = gnt1 ? 1 : 0;
          gc[ng] = c;
        end
        ng++;
      end
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    check("hold grant count", ng, 4);
    for (int j = 0; j < 4; j++) begin
      ep = pick_port(1'b1, 1'b1);
      check($sformatf("hold grant%0d port", j), gp[j], ep);
      check($sformatf("hold grant%0d cycle", j), gc[j], 4 * j);
      model_last = (ep == 1);
    end

    for (int i = 0; i < 10; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

    // req1 pulsed for one cycle while port 0 is mid-transaction must be dropped.
    req0 = 1'b1; we0 = 1'b0; addr0 = 33;
    @(negedge clk);
    check("pulse grant0", {gnt1, gnt0}, 2'b01);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 40; wdata1 = 32'h77;
    n1 = 0; v0n = 0; d = '0;
    @(negedge clk);
    if (gnt1 || rsp_valid1) n1++;
    @(posedge clk); #1;
    req1 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (gnt1 || rsp_valid1) n1++;
      if (rsp_valid0) begin
        v0n++;
        d = rsp_data;
      end
    end
    @(posedge clk); #1;
    check("pulse req1 never served", n1, 0);
    check("pulse rsp_valid0 count", v0n, 1);
    check("pulse rsp_data", d, 32'd33);
    model_last = 1'b0;

    // Asynchronous reset during the ACCESS cycle of a write.
    req0 = 1'b1; we0 = 1'b1; addr0 = 20; wdata0 = 32'h55;
    @(negedge clk);
    check("rst txn grant0", gnt0, 1'b1);
    @(posedge clk); #1;
    req0 = 1'b0; we0 = 1'b0;
    check("rst txn write strobe", mem_write, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("mid-access reset outputs", all_outs(), 128'b0);
    @(negedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    any = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      any = any | rsp_valid0 | rsp_valid1 | busy;
    end
    check("no response after reset", any, 1'b0);
    @(posedge clk); #1;
    model_last = 1'b1;
    run_txn("post-reset read20", mk(1, 0, 0, 0, 20, 0, 0, 0, 0, 20, 0));

    for (int i = 0; i < 40; i++) begin
      rv.r0 = 1'($urandom_range(0, 1));
      rv.r1 = 1'($urandom_range(0, 1));
      if (!rv.r0 && !rv.r1) rv.r1 = 1'b1;
      rv.we0 = 1'($urandom_range(0, 1));
      rv.we1 = 1'($urandom_range(0, 1));
      rv.a0 = ($urandom_range(0, 7) == 0) ? 32'd256 + $urandom_range(0, 5000)
                                          : 32'($urandom_range(0, 255));
      rv.a1 = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
      rv.d0 = $urandom;
      rv.d1 = $urandom;
      rv.ep = pick_port(rv.r0, rv.r1);
      d = (rv.ep == 0) ? rv.a0 : rv.a1;
      rv.eerr = (d >= 32'd256);
      rv.edata = (rv.eerr || ((rv.ep == 0) ? rv.we0 : rv.we1)) ? 32'd0 : ref_mem[d[7:0]];
      run_txn($sformatf("rand%0d", i), rv);
    end

    check("bus monitor violations", mon_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
